// File: rtl/wall_collision_if.sv
// Signal bundle between the motion stage and the wall collision checker.
// The master drives the proposed position, walls and frame strobe; the slave returns hit status.
interface wall_collision_if;
    logic       frame_clk;
    logic [9:0] Next_X;
    logic [9:0] Next_Y;
    logic [9:0] X1;
    logic [9:0] X2;
    logic [9:0] X3;
    logic [9:0] X4;
    logic [9:0] Y1;
    logic [9:0] Y2;
    logic [9:0] Y3;
    logic [9:0] Y4;
    logic [3:0] hit;
    logic       any_hit;
    logic       check_done;
    logic       busy;

    modport master (
        output frame_clk, Next_X, Next_Y, X1, X2, X3, X4, Y1, Y2, Y3, Y4,
        input  hit, any_hit, check_done, busy
    );

    modport slave (
        input  frame_clk, Next_X, Next_Y, X1, X2, X3, X4, Y1, Y2, Y3, Y4,
        output hit, any_hit, check_done, busy
    );
endinterface

// File: rtl/wall_collision.sv
// Per-frame collision check of the proposed object box against four walls,
// evaluated one wall per cycle on a snapshot taken at the rising edge of frame_clk.
module wall_collision #(
    parameter logic [9:0] Hor_Width   = 10'd64,
    parameter logic [9:0] Hor_Height  = 10'd32,
    parameter logic [9:0] Vert_Width  = 10'd32,
    parameter logic [9:0] Vert_Height = 10'd64,
    parameter logic [9:0] Obj_Size    = 10'd31
) (
    input logic             Clk,
    input logic             Reset,
    wall_collision_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCheck, StDone} state_e;

    state_e      state_q, state_d;
    logic        fc_d;
    logic        start;
    logic [9:0]  nx_q, ny_q;
    logic [9:0]  wx_q [4];
    logic [9:0]  wy_q [4];
    logic [1:0]  idx_q;
    logic [3:0]  work_q;
    logic [3:0]  hit_q;
    logic        any_hit_q;
    logic        done_q;

    logic [9:0]  sel_w, sel_h;
    logic [10:0] obj_x0, obj_x1, obj_y0, obj_y1;
    logic [10:0] wall_x0, wall_x1, wall_y0, wall_y1;
    logic        overlap;
    logic [3:0]  work_next;

    assign start = bus.frame_clk & ~fc_d;

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StCheck;
            StCheck: if (idx_q == 2'd3) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        bus.busy       = (state_q != StIdle);
        bus.hit        = hit_q;
        bus.any_hit    = any_hit_q;
        bus.check_done = done_q;
    end

    // Even indices are the horizontal walls 1 and 3, odd ones the vertical walls 2 and 4.
    // Everything is widened to 11 bits so box edges near 1023 cannot wrap.
    always_comb begin
        sel_w     = idx_q[0] ? Vert_Width  : Hor_Width;
        sel_h     = idx_q[0] ? Vert_Height : Hor_Height;
        obj_x0    = {1'b0, nx_q};
        obj_y0    = {1'b0, ny_q};
        obj_x1    = {1'b0, nx_q} + {1'b0, Obj_Size};
        obj_y1    = {1'b0, ny_q} + {1'b0, Obj_Size};
        wall_x0   = {1'b0, wx_q[idx_q]};
        wall_y0   = {1'b0, wy_q[idx_q]};
        wall_x1   = {1'b0, wx_q[idx_q]} + {1'b0, sel_w};
        wall_y1   = {1'b0, wy_q[idx_q]} + {1'b0, sel_h};
        overlap   = (obj_x0 <= wall_x1) && (obj_x1 >= wall_x0) &&
                    (obj_y0 <= wall_y1) && (obj_y1 >= wall_y0);
        work_next = work_q | ({3'b000, overlap} << idx_q);
    end

    // Snapshot, per-wall accumulation and result registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fc_d      <= 1'b0;
            nx_q      <= '0;
            ny_q      <= '0;
            idx_q     <= '0;
            work_q    <= '0;
            hit_q     <= '0;
            any_hit_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                wx_q[i] <= '0;
                wy_q[i] <= '0;
            end
        end else begin
            fc_d   <= bus.frame_clk;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        nx_q    <= bus.Next_X;
                        ny_q    <= bus.Next_Y;
                        wx_q[0] <= bus.X1;
                        wx_q[1] <= bus.X2;
                        wx_q[2] <= bus.X3;
                        wx_q[3] <= bus.X4;
                        wy_q[0] <= bus.Y1;
                        wy_q[1] <= bus.Y2;
                        wy_q[2] <= bus.Y3;
                        wy_q[3] <= bus.Y4;
                        work_q  <= '0;
                        idx_q   <= '0;
                    end
                end
                StCheck: begin
                    work_q <= work_next;
                    idx_q  <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        hit_q     <= work_next;
                        any_hit_q <= |work_next;
                        done_q    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wall_collision.sv
// Directed bench for wall_collision: hand-computed hit vectors, boundary, overflow,
// retrigger, snapshot and reset-abort cases.
module tb_wall_collision;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    wall_collision_if bus ();

    wall_collision #(
        .Hor_Width   (10'd64),
        .Hor_Height  (10'd32),
        .Vert_Width  (10'd32),
        .Vert_Height (10'd64),
        .Obj_Size    (10'd31)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Raises frame_clk and watches 8 cycles; retrig changes Next_X after the latch and
    // raises frame_clk a second time while the check is still running.
    task automatic run(input string tag, input logic [9:0] nx, input logic [9:0] ny,
                       input logic [3:0] exp_hit, input bit retrig);
        int         lat   = 0;
        int         nbusy = 0;
        int         ndone = 0;
        logic [3:0] h     = 4'b0;
        logic       a     = 1'b0;
        bus.Next_X    = nx;
        bus.Next_Y    = ny;
        bus.frame_clk = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.check_done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    h   = bus.hit;
                    a   = bus.any_hit;
                end
            end
            if (c == 1) begin
                bus.frame_clk = 1'b0;
                if (retrig) bus.Next_X = 10'd200;
            end
            if (c == 2 && retrig) bus.frame_clk = 1'b1;
            if (c == 3) bus.frame_clk = 1'b0;
        end
        check({tag, "_latency"}, lat, 5);
        check({tag, "_done_pulses"}, ndone, 1);
        check({tag, "_busy_cycles"}, nbusy, 5);
        check({tag, "_hit"}, {28'd0, h}, {28'd0, exp_hit});
        check({tag, "_any_hit"}, {31'd0, a}, {31'd0, |exp_hit});
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.frame_clk = 1'b0;
        bus.Next_X    = 10'd0;
        bus.Next_Y    = 10'd0;
        bus.X1 = 10'd10;  bus.Y1 = 10'd20;
        bus.X2 = 10'd400; bus.Y2 = 10'd200;
        bus.X3 = 10'd320; bus.Y3 = 10'd240;
        bus.X4 = 10'd600; bus.Y4 = 10'd400;
        repeat (3) @(negedge clk);
        check("rst_hit", {28'd0, bus.hit}, 32'd0);
        check("rst_any_hit", {31'd0, bus.any_hit}, 32'd0);
        check("rst_check_done", {31'd0, bus.check_done}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("origin",   10'd0,   10'd0,   4'b0001, 1'b0);
        run("wall2",    10'd390, 10'd250, 4'b0010, 1'b0);
        run("clear",    10'd200, 10'd100, 4'b0000, 1'b0);
        run("edge_in",  10'd43,  10'd52,  4'b0001, 1'b0);
        run("edge_out", 10'd43,  10'd53,  4'b0000, 1'b0);
        run("past639",  10'd620, 10'd470, 4'b0000, 1'b0);
        run("wall4",    10'd620, 10'd440, 4'b1000, 1'b0);

        repeat (3) @(negedge clk);
        check("hold_hit", {28'd0, bus.hit}, 32'd8);
        check("hold_any_hit", {31'd0, bus.any_hit}, 32'd1);

        run("retrig", 10'd0, 10'd0, 4'b0001, 1'b1);

        // Wall near the top of the 10-bit range: X1+Hor_Width = 1064 must not wrap
        bus.X1 = 10'd1000;
        run("wide_sum", 10'd1010, 10'd20, 4'b0001, 1'b0);
        bus.X1 = 10'd10;

        // Abort mid-check with frame_clk held high through reset release
        bus.Next_X    = 10'd0;
        bus.Next_Y    = 10'd0;
        bus.frame_clk = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_hit", {28'd0, bus.hit}, 32'd0);
        check("abort_any_hit", {31'd0, bus.any_hit}, 32'd0);
        check("abort_check_done", {31'd0, bus.check_done}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("abort_no_done", {31'd0, bus.check_done}, 32'd0);
        rst_n = 1'b1;
        run("after_rst", 10'd390, 10'd250, 4'b0010, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
